// File: rtl/uart_r.sv
// rtl/uart_r.sv - serial receiver with a one-entry valid/ready holding register.
// Optional two-flop input synchronizer: define UART_RX_SYNC_EN.
module uart_r #(
    parameter int D_WIDTH      = 13,
    parameter int CLKS_PER_BIT = 1,
    parameter int CNT_WIDTH    = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx,
    input  logic               rx_ready,
    output logic [D_WIDTH-1:0] rx_data,
    output logic               rx_valid,
    output logic               rx_busy,
    output logic               frame_err,
    output logic               overrun
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    localparam int HALF = (CLKS_PER_BIT - 1) / 2;
    localparam logic [CNT_WIDTH-1:0] BIT_RELOAD  = CNT_WIDTH'(CLKS_PER_BIT - 1);
    localparam logic [CNT_WIDTH-1:0] HALF_RELOAD = CNT_WIDTH'((HALF > 0) ? HALF - 1 : 0);
    localparam logic [CNT_WIDTH-1:0] LAST_BIT    = CNT_WIDTH'(D_WIDTH - 1);

    logic rx_s;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx};
        end
    end

    assign rx_s = sync_q[1];
`else
    assign rx_s = rx;
`endif

    state_t               state, state_n;
    logic [CNT_WIDTH-1:0] timer, timer_n;
    logic [CNT_WIDTH-1:0] bit_cnt, bit_n;
    logic [D_WIDTH-1:0]   shreg, shreg_n;
    logic                 word_done;
    logic                 stop_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            timer   <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_n;
            timer   <= timer_n;
            bit_cnt <= bit_n;
            shreg   <= shreg_n;
        end
    end

    always_comb begin
        state_n   = state;
        timer_n   = timer;
        bit_n     = bit_cnt;
        shreg_n   = shreg;
        word_done = 1'b0;
        stop_err  = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    // With a zero half-bit offset the start sample is this very cycle.
                    if (HALF == 0) begin
                        state_n = DATA;
                        timer_n = BIT_RELOAD;
                        bit_n   = '0;
                    end else begin
                        state_n = START;
                        timer_n = HALF_RELOAD;
                    end
                end
            end
            START: begin
                if (timer == '0) begin
                    if (rx_s) begin
                        state_n = IDLE;
                    end else begin
                        state_n = DATA;
                        timer_n = BIT_RELOAD;
                        bit_n   = '0;
                    end
                end else begin
                    timer_n = timer - 1'b1;
                end
            end
            DATA: begin
                if (timer == '0) begin
                    shreg_n = D_WIDTH'({rx_s, shreg} >> 1);
                    timer_n = BIT_RELOAD;
                    if (bit_cnt == LAST_BIT) begin
                        state_n = STOP;
                    end else begin
                        bit_n = bit_cnt + 1'b1;
                    end
                end else begin
                    timer_n = timer - 1'b1;
                end
            end
            STOP: begin
                if (timer == '0) begin
                    if (rx_s) begin
                        word_done = 1'b1;
                        state_n   = IDLE;
                    end else begin
                        stop_err = 1'b1;
                        state_n  = WAIT_HIGH;
                    end
                end else begin
                    timer_n = timer - 1'b1;
                end
            end
            WAIT_HIGH: begin
                if (rx_s) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign rx_busy = (state != IDLE);

    // A completing word may replace one that is being consumed this same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_err;
            overrun   <= 1'b0;
            if (word_done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shreg;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_r.sv
// tb/tb_uart_r.sv - directed self-checking bench for uart_r.
module tb_uart_r;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx;
    logic        rx_ready;
    logic [12:0] rx_data;
    logic        rx_valid;
    logic        rx_busy;
    logic        frame_err;
    logic        overrun;

    logic        rx4;
    logic        rx_ready4;
    logic [12:0] rx_data4;
    logic        rx_valid4;
    logic        rx_busy4;
    logic        frame_err4;
    logic        overrun4;

    int tests_run    = 0;
    int tests_failed = 0;

    int          ferr_cnt = 0;
    int          ovr_cnt  = 0;
    logic [12:0] got_q[$];
    int          valid4_cnt = 0;
    int          ferr4_cnt  = 0;
    logic [12:0] last4 = '0;

    always #5 clk = ~clk;

    uart_r #(.D_WIDTH(13), .CLKS_PER_BIT(1), .CNT_WIDTH(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_ready  (rx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_busy   (rx_busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    uart_r #(.D_WIDTH(13), .CLKS_PER_BIT(4), .CNT_WIDTH(5)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx4),
        .rx_ready  (rx_ready4),
        .rx_data   (rx_data4),
        .rx_valid  (rx_valid4),
        .rx_busy   (rx_busy4),
        .frame_err (frame_err4),
        .overrun   (overrun4)
    );

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid && rx_ready) got_q.push_back(rx_data);
            if (frame_err) ferr_cnt++;
            if (overrun) ovr_cnt++;
            if (rx_valid4 && rx_ready4) begin
                valid4_cnt++;
                last4 = rx_data4;
            end
            if (frame_err4) ferr4_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [12:0] w, input logic stop_bit);
        rx = 1'b0;
        tick();
        for (int i = 0; i < 13; i++) begin
            rx = w[i];
            tick();
        end
        rx = stop_bit;
        tick();
    endtask

    task automatic send_frame4(input logic [12:0] w);
        logic [14:0] f;
        f = {1'b1, w, 1'b0};
        for (int i = 0; i < 15; i++) begin
            rx4 = f[i];
            repeat (4) tick();
        end
    endtask

    initial begin
        logic [12:0] exp_q[$];
        logic [12:0] w;
        int          ferr_snap;
        int          ovr_snap;

        rst = 1'b1; rx = 1'b1; rx_ready = 1'b1; rx4 = 1'b1; rx_ready4 = 1'b1;
        repeat (3) tick();
        check("reset_valid", {31'b0, rx_valid}, 32'd0);
        check("reset_busy", {31'b0, rx_busy}, 32'd0);
        check("reset_data", {19'b0, rx_data}, 32'd0);
        check("reset_ferr", {30'b0, frame_err, overrun}, 32'd0);
        check("reset4_busy", {30'b0, rx_busy4, rx_valid4}, 32'd0);
        rst = 1'b0;
        tick();

        // single frame
        send_frame(13'h1A5C, 1'b1);
        rx = 1'b1;
        check("t1_valid", {31'b0, rx_valid}, 32'd1);
        check("t1_data", {19'b0, rx_data}, 32'h1A5C);
        tick();
        check("t1_valid_clear", {31'b0, rx_valid}, 32'd0);
        check("t1_errs", ferr_cnt + ovr_cnt, 32'd0);

        // back-to-back with consumer stalled
        rx_ready = 1'b0;
        send_frame(13'h0001, 1'b1);
        rx = 1'b1;
        check("t2_first_valid", {31'b0, rx_valid}, 32'd1);
        tick();
        send_frame(13'h1FFF, 1'b1);
        rx = 1'b1;
        check("t2_overrun_pulse", {31'b0, overrun}, 32'd1);
        check("t2_data_kept", {19'b0, rx_data}, 32'h0001);
        tick();
        check("t2_overrun_low", {31'b0, overrun}, 32'd0);
        check("t2_still_valid", {31'b0, rx_valid}, 32'd1);
        check("t2_overrun_cnt", ovr_cnt, 32'd1);
        rx_ready = 1'b1;
        tick();
        check("t2_valid_drop", {31'b0, rx_valid}, 32'd0);

        // bad stop bit followed by a held-low break
        send_frame(13'h0F0F, 1'b0);
        check("t3_ferr_pulse", {31'b0, frame_err}, 32'd1);
        check("t3_no_valid", {31'b0, rx_valid}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_busy_low", {31'b0, rx_busy}, 32'd1);
        end
        rx = 1'b1;
        tick();
        check("t3_idle", {31'b0, rx_busy}, 32'd0);
        check("t3_ferr_cnt", ferr_cnt, 32'd1);
        check("t3_valid_cnt", {31'b0, rx_valid}, 32'd0);

        // reset mid-frame
        w = 13'h0AAA;
        rx = 1'b0;
        tick();
        for (int i = 0; i < 7; i++) begin
            rx = w[i];
            tick();
        end
        check("t5_busy_before", {31'b0, rx_busy}, 32'd1);
        rst = 1'b1;
        tick();
        check("t5_rst_busy", {31'b0, rx_busy}, 32'd0);
        check("t5_rst_data", {19'b0, rx_data}, 32'd0);
        check("t5_rst_flags", {29'b0, rx_valid, frame_err, overrun}, 32'd0);
        rst = 1'b0; rx = 1'b1;
        tick();
        send_frame(13'h0555, 1'b1);
        rx = 1'b1;
        check("t5_clean_valid", {31'b0, rx_valid}, 32'd1);
        check("t5_clean_data", {19'b0, rx_data}, 32'h0555);
        tick();

        // glitch and a full frame at four clocks per bit
        rx4 = 1'b0;
        tick();
        check("t4_glitch_busy", {31'b0, rx_busy4}, 32'd1);
        rx4 = 1'b1;
        tick();
        check("t4_glitch_idle", {31'b0, rx_busy4}, 32'd0);
        tick();
        check("t4_glitch_quiet", valid4_cnt + ferr4_cnt, 32'd0);
        send_frame4(13'h1234);
        rx4 = 1'b1;
        tick();
        check("t4_frame_cnt", valid4_cnt, 32'd1);
        check("t4_frame_data", {19'b0, last4}, 32'h1234);
        check("t4_ferr", ferr4_cnt, 32'd0);

        // back-to-back random stream
        got_q.delete();
        ferr_snap = ferr_cnt;
        ovr_snap  = ovr_cnt;
        for (int i = 0; i < 20; i++) begin
            w = 13'($urandom);
            exp_q.push_back(w);
            send_frame(w, 1'b1);
        end
        rx = 1'b1;
        tick();
        tick();
        check("t6_count", got_q.size(), 32'd20);
        for (int i = 0; i < 20; i++) begin
            if (i < got_q.size()) check($sformatf("t6_word%0d", i), {19'b0, got_q[i]}, {19'b0, exp_q[i]});
        end
        check("t6_errs", (ferr_cnt - ferr_snap) + (ovr_cnt - ovr_snap), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/uart_r.md
Name: uart_r

Overview:
- Serial receiver that sits directly downstream of the UART transmitter. It consumes the transmitter's `tx` line and recovers each D_WIDTH-bit data word.
- Frame format: idle-high line, one start bit (0), D_WIDTH data bits LSB-first, then at least one stop bit (1).
- Recovered words go to the consumer through a one-entry valid/ready holding register.
- Frame errors and overruns are flagged as one-cycle pulses.

Parameters:
- D_WIDTH, 13, data bits per frame; must match the transmitter.
- CLKS_PER_BIT, 1, clock cycles per serial bit; must be >= 1. The value 1 matches the transmitter's one-bit-per-clock rate.
- CNT_WIDTH, 5, width of the bit counter and the cycle timer; must hold max(D_WIDTH, CLKS_PER_BIT).

Ports:
- clk  input  1  system clock, all logic on its rising edge
- rst  input  1  reset, synchronous and active-high
- rx  input  1  serial line, idle high
- rx_ready  input  1  consumer accepts rx_data this cycle
- rx_data  output  D_WIDTH  last received word, LSB = first data bit
- rx_valid  output  1  rx_data holds an unconsumed word
- rx_busy  output  1  a frame is in progress
- frame_err  output  1  one-cycle pulse: stop bit sampled 0
- overrun  output  1  one-cycle pulse: a frame completed while the holding register was full

Behaviour:
- Reset:
  - Synchronous, evaluated every posedge, overrides all else.
  - State goes to IDLE; counters go to 0.
  - rx_data=0, rx_valid=0, rx_busy=0, frame_err=0, overrun=0.
  - A reset mid-frame aborts the frame silently.
- Sample timing: let t0 be the cycle in which IDLE first samples rx=0. Sample points are:
  - start bit at t0+(CLKS_PER_BIT-1)/2 (integer division);
  - data bit i (0..D_WIDTH-1) at that point +(i+1)*CLKS_PER_BIT;
  - stop bit at that point +(D_WIDTH+1)*CLKS_PER_BIT.
  - With CLKS_PER_BIT=1, every bit is sampled on consecutive cycles starting at t0.
- States:
  - IDLE: rx_busy=0. On rx=0, load the timer, then go to START, or evaluate the start sample in the same cycle if CLKS_PER_BIT=1.
  - START: at the sample point, rx=1 is a glitch: return to IDLE with no flag. rx=0 goes to DATA with bit counter 0.
  - DATA: at each sample point, shift rx in at the MSB side, so the first bit ends at bit 0. After bit D_WIDTH-1, go to STOP.
  - STOP: at the sample point:
    - rx=1: the word is complete; go to IDLE.
    - rx=0: pulse frame_err next cycle, discard the word, go to WAIT_HIGH.
  - WAIT_HIGH: rx_busy=1. Stay until rx=1, then go to IDLE. This prevents a held-low break from retriggering.
- rx_busy = 1 in every state except IDLE.
- Output holding register:
  - A complete word is loaded into rx_data and rx_valid is set in the cycle after the stop sample (latency 1).
  - Transfer occurs when rx_valid & rx_ready; rx_valid clears next cycle.
  - Completion in the same cycle as a transfer: the new word loads and rx_valid stays 1, with no overrun.
  - Completion while rx_valid=1 and rx_ready=0: the old word is kept, the new word is dropped, and overrun pulses one cycle.
- Back-to-back frames: the receiver returns to IDLE on the stop sample and accepts a start bit on the very next cycle.
- Counters never wrap in legal operation. The timer reloads to CLKS_PER_BIT-1 at each sample point.

Optional Feature:
- Macro: UART_RX_SYNC_EN.
- Defined:
  - rx passes through a two-flop synchronizer, both flops reset to 1, before any FSM use.
  - All sample points and rx_valid/frame_err timing shift 2 cycles later.
  - Required when rx comes from another clock domain.
- Undefined: rx is used directly; it must be synchronous to clk.

Test Plan:
- Directed single frame, CLKS_PER_BIT=1, rx_ready=1: send 13'h1A5C as start + LSB-first bits + stop -> rx_valid high for exactly 1 cycle, 1 cycle after the stop sample, with rx_data=13'h1A5C; frame_err=0, overrun=0.
- Back-to-back frames 13'h0001 then 13'h1FFF, with one idle-high cycle between them, rx_ready=0 after the first -> rx_data stays 13'h0001, rx_valid stays 1, overrun pulses once; then raise rx_ready -> rx_valid drops next cycle.
- Stop bit forced to 0, then rx held low for 5 cycles -> frame_err pulses once, rx_valid stays 0, rx_busy stays 1 until rx returns high, then idle.
- Glitch: rx low for 1 cycle with CLKS_PER_BIT=4 (the sample at t0+1 sees 1) -> no rx_valid, no frame_err, back to IDLE.
- Reset mid-frame: assert rst after data bit 6 of 13'h0AAA -> next cycle all outputs 0 and rx_busy=0; the next clean frame 13'h0555 is received correctly.
- Loopback with the transmitter (tx -> rx), 20 random words at CLKS_PER_BIT=1, rx_ready=1 -> every word is received in order, with no error pulses.
